// File: rtl/dffram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dffram_arbiter_pkg
// Description : Shared types and constants for the two-port DFFRAM arbiter.
//               - port_idx_t : identifies requester port 0 or port 1
//               - c_WE_READ  : byte-write-enable pattern that denotes a read
// Revision    : 1.0 - initial release
// ============================================================================
package dffram_arbiter_pkg;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_idx_t;

  localparam logic [3:0] c_WE_READ = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/dffram_arbiter_rr_lock_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arb
// Description : Two-way round-robin arbiter with a burst lock counter.
//               The previous winner keeps the grant while it holds req+lock
//               and has had fewer than MAX_LOCK consecutive grants; otherwise
//               contention is resolved in favour of the port not granted last.
// Ports       : CLK, RST  - clock, asynchronous active-high reset
//               req[1:0]  - per-port requests
//               lock[1:0] - per-port burst lock requests
//               gnt[1:0]  - one-hot (or zero) grant, combinational
//               sel       - winning port index (valid when gnt != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arb
  import dffram_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt,
  output port_idx_t  sel
);

  localparam int                  c_CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [c_CNT_W-1:0]  c_MAX   = c_CNT_W'(MAX_LOCK);
  localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);

  port_idx_t          r_last_gnt;
  logic [c_CNT_W-1:0] r_lock_cnt;

  logic      w_hold;
  port_idx_t w_win;

  // A non-zero count means the last-granted port also won the previous cycle,
  // so it is the only port that may be holding a lock.
  always_comb begin
    w_hold = (r_lock_cnt != '0) && (r_lock_cnt < c_MAX) &&
             req[r_last_gnt] && lock[r_last_gnt];
    w_win  = PORT_0;
    if (w_hold) begin
      w_win = r_last_gnt;
    end else if (&req) begin
      w_win = (r_last_gnt == PORT_0) ? PORT_1 : PORT_0;
    end else if (req[1]) begin
      w_win = PORT_1;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if ((|req) && !RST) begin
      gnt[w_win] = 1'b1;
    end
  end

  assign sel = w_win;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_gnt <= PORT_1;
      r_lock_cnt <= '0;
    end else if (|gnt) begin
      r_last_gnt <= w_win;
      if ((w_win == r_last_gnt) && lock[w_win] && (r_lock_cnt != '0)) begin
        // Saturate so a lone locking requester cannot wrap the counter.
        if (r_lock_cnt < c_MAX) begin
          r_lock_cnt <= r_lock_cnt + c_ONE;
        end
      end else begin
        r_lock_cnt <= c_ONE;
      end
    end else begin
      r_lock_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dffram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dffram_arbiter
// Description : Two-port front end for a single-port DFFRAM. Arbitrates port
//               requests (round-robin with burst lock), steers the winner's
//               command to the RAM in the grant cycle and returns read data
//               one cycle later on the requesting port.
// Ports       : CLK, RST              - clock, asynchronous active-high reset
//               pN_req/lock/we/a/di   - port N command (N = 0, 1)
//               pN_gnt                - port N accepted this cycle
//               pN_rvalid/pN_do       - port N read response (do = 0 if idle)
//               ram_en/we/a/di        - DFFRAM command
//               ram_do                - DFFRAM read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_arbiter
  import dffram_arbiter_pkg::*;
#(
  parameter  int COLS     = 1,
  parameter  int MAX_LOCK = 8,
  localparam int A_WIDTH  = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               p0_req,
  input  logic               p0_lock,
  input  logic [3:0]         p0_we,
  input  logic [A_WIDTH-1:0] p0_a,
  input  logic [31:0]        p0_di,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [31:0]        p0_do,
  input  logic               p1_req,
  input  logic               p1_lock,
  input  logic [3:0]         p1_we,
  input  logic [A_WIDTH-1:0] p1_a,
  input  logic [31:0]        p1_di,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [31:0]        p1_do,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [31:0]        ram_di,
  input  logic [31:0]        ram_do
);

  logic [1:0] w_gnt;
  port_idx_t  w_sel;
  logic       w_rd_issue;

  logic       r_rvalid;
  port_idx_t  r_rsel;

  rr_lock_arb #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .CLK  (CLK),
    .RST  (RST),
    .req  ({p1_req, p0_req}),
    .lock ({p1_lock, p0_lock}),
    .gnt  (w_gnt),
    .sel  (w_sel)
  );

  assign p0_gnt = w_gnt[0];
  assign p1_gnt = w_gnt[1];

  // Command steering: the RAM bus is all-zero when nobody is granted.
  always_comb begin
    ram_en = |w_gnt;
    ram_we = 4'b0000;
    ram_a  = '0;
    ram_di = 32'h0;
    if (w_gnt[1]) begin
      ram_we = p1_we;
      ram_a  = p1_a;
      ram_di = p1_di;
    end else if (w_gnt[0]) begin
      ram_we = p0_we;
      ram_a  = p0_a;
      ram_di = p0_di;
    end
  end

  assign w_rd_issue = ram_en && (ram_we == c_WE_READ);

  // Single-stage response pipeline matching the RAM's read latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rvalid <= 1'b0;
      r_rsel   <= PORT_0;
    end else begin
      r_rvalid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rsel <= w_sel;
      end
    end
  end

  assign p0_rvalid = r_rvalid && (r_rsel == PORT_0);
  assign p1_rvalid = r_rvalid && (r_rsel == PORT_1);
  assign p0_do     = p0_rvalid ? ram_do : 32'h0;
  assign p1_do     = p1_rvalid ? ram_do : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dffram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dffram_arbiter
// Description : Self-checking bench for dffram_arbiter with a behavioural
//               DFFRAM, an arbitration reference model and a read-response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dffram_arbiter;

  localparam int COLS     = 1;
  localparam int MAX_LOCK = 8;
  localparam int AW       = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0]    p0_we, p1_we;
  logic [AW-1:0] p0_a, p1_a;
  logic [31:0]   p0_di, p1_di;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0]   p0_do, p1_do;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di, ram_do;

  always #5 CLK = ~CLK;

  dffram_arbiter #(
    .COLS     (COLS),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .p0_req    (p0_req),
    .p0_lock   (p0_lock),
    .p0_we     (p0_we),
    .p0_a      (p0_a),
    .p0_di     (p0_di),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_do     (p0_do),
    .p1_req    (p1_req),
    .p1_lock   (p1_lock),
    .p1_we     (p1_we),
    .p1_a      (p1_a),
    .p1_di     (p1_di),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_do     (p1_do),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  // Behavioural DFFRAM: read-before-write, Do registered, zero when EN low.
  logic [31:0] mem [0:255];
  logic [31:0] ram_do_r;
  logic        mem_init = 1'b1;
  assign ram_do = ram_do_r;

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hFFFFFFFF;
      ram_do_r   <= 32'h0;
    end else if (ram_en) begin
      ram_do_r <= mem[ram_a];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end else begin
      ram_do_r <= 32'h0;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  logic m_last;
  int   m_cnt;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive both ports, check the pending response, then check
  // the combinational grant/RAM command against the reference arbiter.
  task automatic step(
    input logic r0, input logic l0, input logic [3:0] we0, input logic [7:0] a0, input logic [31:0] d0,
    input logic r1, input logic l1, input logic [3:0] we1, input logic [7:0] a1, input logic [31:0] d1);
    logic [1:0] req, lk, eg;
    logic       hold, w;
    rsp_t       e;
    @(negedge CLK);
    p0_req = r0; p0_lock = l0; p0_we = we0; p0_a = a0; p0_di = d0;
    p1_req = r1; p1_lock = l1; p1_we = we1; p1_a = a1; p1_di = d1;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rvalid0", {31'h0, p0_rvalid}, {31'h0, e.port == 1'b0});
      chk("rvalid1", {31'h0, p1_rvalid}, {31'h0, e.port == 1'b1});
      chk("rdata", e.port ? p1_do : p0_do, e.data);
      chk("other_do", e.port ? p0_do : p1_do, 32'h0);
    end else begin
      chk("rvalid0_idle", {31'h0, p0_rvalid}, 32'h0);
      chk("rvalid1_idle", {31'h0, p1_rvalid}, 32'h0);
      chk("p0_do_idle", p0_do, 32'h0);
      chk("p1_do_idle", p1_do, 32'h0);
    end
    req  = {r1, r0};
    lk   = {l1, l0};
    hold = (m_cnt != 0) && (m_cnt < MAX_LOCK) && req[m_last] && lk[m_last];
    if (hold)          w = m_last;
    else if (r0 && r1) w = ~m_last;
    else               w = r1;
    eg = (req == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
    chk("gnt", {30'h0, p1_gnt, p0_gnt}, {30'h0, eg});
    chk("ram_en", {31'h0, ram_en}, {31'h0, |eg});
    if (eg != 2'b00) begin
      chk("ram_we", {28'h0, ram_we}, {28'h0, (w ? we1 : we0)});
      chk("ram_a", {24'h0, ram_a}, {24'h0, (w ? a1 : a0)});
      chk("ram_di", ram_di, w ? d1 : d0);
      if ((w ? we1 : we0) == 4'b0000) sb.push_back('{w, mem[w ? a1 : a0]});
      if ((w == m_last) && lk[w] && (m_cnt != 0)) begin
        if (m_cnt < MAX_LOCK) m_cnt = m_cnt + 1;
      end else begin
        m_cnt = 1;
      end
      m_last = w;
    end else begin
      chk("ram_we_idle", {28'h0, ram_we}, 32'h0);
      chk("ram_a_idle", {24'h0, ram_a}, 32'h0);
      chk("ram_di_idle", ram_di, 32'h0);
      m_cnt = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
  endtask

  initial begin
    p0_req = 0; p0_lock = 0; p0_we = 0; p0_a = 0; p0_di = 0;
    p1_req = 0; p1_lock = 0; p1_we = 0; p1_a = 0; p1_di = 0;
    m_last = 1'b1;
    m_cnt  = 0;

    // Outputs forced low while reset is held, even with a request present.
    @(negedge CLK);
    p0_req = 1; p0_a = 8'h10;
    #1;
    chk("rst_p0_gnt", {31'h0, p0_gnt}, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
    chk("rst_p0_do", p0_do, 32'h0);
    @(negedge CLK);
    mem_init = 1'b0;
    RST      = 1'b0;
    p0_req   = 0;

    // Round-robin from reset: p0, p1, p0, p1.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 4'h0, 8'h10, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
      chk("rr_seq_p1", {31'h0, p1_gnt}, 32'(i % 2));
    end
    idle();

    // Single requester read.
    step(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    chk("single_gnt", {31'h0, p0_gnt}, 32'h1);
    idle();
    chk("single_rvalid", {31'h0, p0_rvalid}, 32'h1);
    chk("single_do", p0_do, 32'hDEADBEEF);

    // Partial write then read-after-write.
    step(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'b0011, 8'h20, 32'h12345678);
    step(1, 0, 4'h0, 8'h20, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    idle();
    chk("raw_do", p0_do, 32'hFFFF5678);

    // Lock burst: p0 holds for MAX_LOCK grants, then p1 gets in.
    step(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'h0, 8'h10, 32'h0);
    for (int i = 0; i < MAX_LOCK + 1; i++) begin
      step(1, 1, 4'h0, 8'h10, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
      chk("lock_seq_p1", {31'h0, p1_gnt}, (i == MAX_LOCK) ? 32'h1 : 32'h0);
    end
    idle();

    // Mixed random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           8'($urandom_range(0, 63)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           8'($urandom_range(0, 63)), $urandom);
    end
    idle();

    // Reset asserted in the cycle of a read grant.
    @(negedge CLK);
    p0_req = 1; p0_lock = 0; p0_we = 4'h0; p0_a = 8'h10;
    #1;
    chk("pre_rst_gnt", {31'h0, p0_gnt}, 32'h1);
    RST = 1'b1;
    #1;
    chk("mid_rst_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    chk("mid_rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("mid_rst_ram_we", {28'h0, ram_we}, 32'h0);
    chk("mid_rst_rvalid", {31'h0, p0_rvalid}, 32'h0);
    chk("mid_rst_do", p0_do, 32'h0);
    @(negedge CLK);
    RST    = 1'b0;
    p0_req = 0;
    sb.delete();
    m_last = 1'b1;
    m_cnt  = 0;
    step(1, 0, 4'h0, 8'h10, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
    chk("post_rst_p0_wins", {31'h0, p0_gnt}, 32'h1);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dffram_arbiter.md
DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

Interface
REQ-001 COLS, default 1, number of 256-word columns in the attached DFFRAM; A_WIDTH = 8+$clog2(COLS) (localparam).
REQ-002 MAX_LOCK, default 8, maximum consecutive grants to one locking port before a forced hand-over.
REQ-003 CLK  input  1  single clock; all state on posedge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 pN_req  input  1  port N (N=0,1) access request, held until granted.
REQ-006 pN_lock  input  1  port N requests back-to-back grants (burst).
REQ-007 pN_we  input  4  port N byte write enables; 4'b0000 means read.
REQ-008 pN_a  input  A_WIDTH  port N word address.
REQ-009 pN_di  input  32  port N write data.
REQ-010 pN_gnt  output  1  port N access accepted this cycle.
REQ-011 pN_rvalid  output  1  port N read data valid.
REQ-012 pN_do  output  32  port N read data.
REQ-013 ram_en / ram_we / ram_a / ram_di  output  1/4/A_WIDTH/32  DFFRAM EN/WE/A/Di.
REQ-014 ram_do  input  32  DFFRAM Do (1-cycle latency, zero when EN low).

Function
REQ-015 At most one of p0_gnt/p1_gnt SHALL be high per cycle; pN_gnt = pN_req AND arbitration winner, combinational in the same cycle.
REQ-016 Granted port's we/a/di SHALL drive ram_we/ram_a/ram_di combinationally; ram_en = p0_gnt OR p1_gnt; with no grant, ram_en=0, ram_we=0, ram_a=0, ram_di=0.
REQ-017 Single requester SHALL be granted immediately (zero wait).
REQ-018 Both requesting, no active lock: the port not granted last (last_gnt register) SHALL win (round-robin); after reset last_gnt=1, so port 0 wins first contention.
REQ-019 Lock: if the previous cycle's winner still has req=1 and lock=1 and lock_cnt < MAX_LOCK, it SHALL win regardless of round-robin.
REQ-020 lock_cnt SHALL increment on each consecutive grant to the same port with lock=1, and reset to 1 on a grant to the other port or to 0 on a cycle without grant; at lock_cnt = MAX_LOCK with the other port requesting, the other port SHALL win.
REQ-021 Read (granted we=4'b0000): pN_rvalid SHALL assert exactly one cycle after pN_gnt, for one cycle, with pN_do = ram_do.
REQ-022 Write grants SHALL NOT produce rvalid; write completes in the grant cycle.
REQ-023 pN_do SHALL be 32'b0 whenever pN_rvalid=0.
REQ-024 Back-to-back reads SHALL sustain one grant per cycle; responses in grant order, never reordered.
REQ-025 Read and write to the same address in consecutive cycles: read granted first returns old data; read granted after a write returns new data.
REQ-026 Deasserting req without a grant SHALL be permitted and leave no state change.

Reset
REQ-027 RST high SHALL asynchronously clear last_gnt to 1, lock_cnt to 0, and the response pipeline (rvalid, response port select) to 0.
REQ-028 While RST is high all gnt, rvalid, ram_en, ram_we outputs SHALL be 0 and pN_do 0.
REQ-029 A read granted in the cycle RST asserts SHALL produce no rvalid after reset release.

Structure
REQ-030 A shared package SHALL hold the port-index type (0/1) and the read-opcode constant 4'b0000; A_WIDTH stays local.
REQ-031 One sub-module, rr_lock_arb (2-way round-robin with lock counter), SHALL contain last_gnt and lock_cnt; the top holds muxing and response pipeline.

Verification
REQ-032 Only p0 read a=0x10, RAM[0x10]=0xDEADBEEF -> p0_gnt same cycle, p0_rvalid next cycle with p0_do=0xDEADBEEF.
REQ-033 Both ports read every cycle for 4 cycles, no lock, from reset -> grants p0,p1,p0,p1; rvalids follow one cycle later in same order.
REQ-034 p0 lock=1 req=1 continuously, MAX_LOCK=8, p1 requesting -> p0 granted 8 consecutive cycles, then p1 granted.
REQ-035 p1 write we=4'b0011 a=0x20 di=0x12345678 over RAM 0xFFFFFFFF, then p0 read a=0x20 -> p0_do=0xFFFF5678, no rvalid for the write.
REQ-036 RST asserted in cycle of p0 read grant -> outputs 0 immediately, no p0_rvalid after release, next contention won by p0.
